// File: rtl/cf_math_pkg.sv
// rtl/cf_math_pkg.sv - shared math helpers for parameter derivation
// Purpose: width helpers used when sizing index and counter fields.
// Ports: none (package).
package cf_math_pkg;

  // Width of an index that selects one of num_idx items; never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? int'($clog2(num_idx)) : 1;
  endfunction

endpackage

// File: rtl/stream_xbar_out_fifo.sv
// rtl/stream_xbar_out_fifo.sv - per-output crossbar FIFO with per-source occupancy limit
// Purpose: buffers up to Depth beats in order behind one crossbar output and
//   refuses beats from a source that already holds MaxPerInp entries.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync clear)
//   data_i/idx_i/valid_i/ready_o : upstream stream from the crossbar output
//   data_o/idx_o/valid_o/ready_i : downstream stream, head of the buffer
//   usage_o                      : number of stored entries
//   cnt_o                        : stored entries per source index
module stream_xbar_out_fifo
  import cf_math_pkg::*;
#(
  parameter int unsigned NumInp    = 0,
  parameter int unsigned Depth     = 4,
  parameter int unsigned MaxPerInp = Depth,
  parameter type         payload_t = logic [31:0],
  // Derived; left as parameters only because port widths need them.
  parameter int unsigned IdxWidth  = idx_width(NumInp),
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  payload_t                           data_i,
  input  logic [IdxWidth-1:0]                idx_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output payload_t                           data_o,
  output logic [IdxWidth-1:0]                idx_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [CntWidth-1:0]                usage_o,
  output logic [NumInp-1:0][CntWidth-1:0]    cnt_o
);

  localparam int unsigned           PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0]   DepthCnt = CntWidth'(Depth);
  localparam logic [CntWidth-1:0]   MaxCnt   = CntWidth'(MaxPerInp);
  localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(Depth - 1);

  if (MaxPerInp < 1 || MaxPerInp > Depth) begin : g_bad_max_per_inp
    $error("MaxPerInp must be in 1..Depth");
  end

  payload_t                        data_q [Depth];
  logic [IdxWidth-1:0]             idx_q  [Depth];
  logic [PtrWidth-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]             usage_q;
  logic [NumInp-1:0][CntWidth-1:0] cnt_q;
  logic [IdxWidth-1:0]             head_idx;
  logic                            push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // ready_o is built from registered state plus idx_i/flush_i only, so the
  // consumer's ready_i never reaches back into the crossbar arbiter. A pop in
  // the same cycle therefore does not open a slot for a push.
  assign ready_o  = !flush_i && (usage_q < DepthCnt) && (cnt_q[idx_i] < MaxCnt);
  assign valid_o  = (usage_q != '0);
  assign push     = valid_i && ready_o;
  // A pop offered during a flush is dropped along with everything else.
  assign pop      = valid_o && ready_i && !flush_i;
  assign head_idx = idx_q[rd_ptr_q];

  // Storage is not reset; the empty-mask keeps stale contents off the outputs.
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign idx_o   = valid_o ? head_idx : '0;
  assign usage_o = usage_q;
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= data_i;
      idx_q[wr_ptr_q]  <= idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      usage_q <= usage_q + 1'b1;
      else if (pop && !push) usage_q <= usage_q - 1'b1;
    end
  end

  // Per-source occupancy: push of k increments, pop of a k-headed beat
  // decrements, both together cancel.
  for (genvar k = 0; k < NumInp; k++) begin : g_cnt
    logic                inc, dec;
    logic [CntWidth-1:0] cnt_k;

    assign inc      = push && (idx_i == IdxWidth'(k));
    assign dec      = pop && (head_idx == IdxWidth'(k));
    assign cnt_q[k] = cnt_k;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        cnt_k <= '0;
      end else if (inc && !dec) begin
        cnt_k <= cnt_k + 1'b1;
      end else if (dec && !inc) begin
        cnt_k <= cnt_k - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) assert (cnt_k <= MaxCnt);
    end
  end

  int unsigned cnt_sum;
  always_comb begin
    cnt_sum = 0;
    for (int k = 0; k < NumInp; k++) cnt_sum += 32'(cnt_q[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (valid_i) assert (32'(idx_i) < NumInp);
      assert (cnt_sum == 32'(usage_q));
    end
  end

endmodule

// File: tb/tb_stream_xbar_out_fifo.sv
// tb/tb_stream_xbar_out_fifo.sv - self-checking bench for stream_xbar_out_fifo
module tb_stream_xbar_out_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  idx_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;

  // a: Depth=4, MaxPerInp=4   b: Depth=4, MaxPerInp=2   c: Depth=3, MaxPerInp=3
  logic        a_ready_o, a_valid_o, b_ready_o, b_valid_o, c_ready_o, c_valid_o;
  logic [31:0] a_data_o, b_data_o, c_data_o;
  logic [1:0]  a_idx_o, b_idx_o, c_idx_o;
  logic [2:0]  a_usage_o, b_usage_o;
  logic [1:0]  c_usage_o;
  logic [3:0][2:0] a_cnt_o, b_cnt_o;
  logic [3:0][1:0] c_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_xbar_out_fifo #(.NumInp(4), .Depth(4), .MaxPerInp(4)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_i), .idx_i(idx_i),
    .valid_i(valid_i), .ready_o(a_ready_o), .data_o(a_data_o), .idx_o(a_idx_o),
    .valid_o(a_valid_o), .ready_i(ready_i), .usage_o(a_usage_o), .cnt_o(a_cnt_o));

  stream_xbar_out_fifo #(.NumInp(4), .Depth(4), .MaxPerInp(2)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_i), .idx_i(idx_i),
    .valid_i(valid_i), .ready_o(b_ready_o), .data_o(b_data_o), .idx_o(b_idx_o),
    .valid_o(b_valid_o), .ready_i(ready_i), .usage_o(b_usage_o), .cnt_o(b_cnt_o));

  stream_xbar_out_fifo #(.NumInp(4), .Depth(3), .MaxPerInp(3)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_i), .idx_i(idx_i),
    .valid_i(valid_i), .ready_o(c_ready_o), .data_o(c_data_o), .idx_o(c_idx_o),
    .valid_o(c_valid_o), .ready_i(ready_i), .usage_o(c_usage_o), .cnt_o(c_cnt_o));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_a(input logic [31:0] d, input logic [1:0] k);
    valid_i = 1'b1; data_i = d; idx_i = k;
    cyc();
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", a_valid_o); end
    checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", a_ready_o); end
    checks++; if (a_usage_o !== 3'd0) begin failures++; $display("FAIL reset_usage got=%0d exp=0", a_usage_o); end
    checks++; if (a_cnt_o !== 12'h0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", a_cnt_o); end
    checks++; if (a_data_o !== 32'h0 || a_idx_o !== 2'd0) begin failures++; $display("FAIL reset_data got=%0h/%0d exp=0/0", a_data_o, a_idx_o); end
  endtask

  task automatic test_fill;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = 32'hA0 + i; idx_i = 2'(i);
      #1;
      checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready%0d got=%0b exp=1", i, a_ready_o); end
      cyc();
      checks++; if (a_usage_o !== 3'(i + 1)) begin failures++; $display("FAIL fill_usage%0d got=%0d exp=%0d", i, a_usage_o, i + 1); end
    end
    checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", a_ready_o); end
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_cnt_o[k] !== 3'd1) begin failures++; $display("FAIL fill_cnt%0d got=%0d exp=1", k, a_cnt_o[k]); end
    end
  endtask

  task automatic test_drain;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_valid_o !== 1'b1 || a_data_o !== 32'hA0 + i || a_idx_o !== 2'(i)) begin
        failures++; $display("FAIL drain%0d got=%0b/%0h/%0d exp=1/%0h/%0d", i, a_valid_o, a_data_o, a_idx_o, 32'hA0 + i, i);
      end
      cyc();
    end
    ready_i = 1'b0;
    checks++; if (a_valid_o !== 1'b0 || a_data_o !== 32'h0) begin failures++; $display("FAIL drain_empty got=%0b/%0h exp=0/0", a_valid_o, a_data_o); end
  endtask

  task automatic test_per_source_limit;
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; idx_i = 2'd1;
    for (int i = 0; i < 3; i++) begin
      data_i = 32'hB0 + i;
      #1;
      checks++; if (b_ready_o !== (i < 2)) begin failures++; $display("FAIL limit_ready%0d got=%0b exp=%0b", i, b_ready_o, i < 2); end
      cyc();
    end
    checks++; if (b_usage_o !== 3'd2 || b_cnt_o[1] !== 3'd2) begin failures++; $display("FAIL limit_usage got=%0d/%0d exp=2/2", b_usage_o, b_cnt_o[1]); end
    idx_i = 2'd2;
    #1;
    checks++; if (b_ready_o !== 1'b1) begin failures++; $display("FAIL limit_other_idx got=%0b exp=1", b_ready_o); end
    valid_i = 1'b0;
    checks++; if (b_data_o !== 32'hB0) begin failures++; $display("FAIL limit_head got=%0h exp=b0", b_data_o); end
    ready_i = 1'b1;
    cyc();
    ready_i = 1'b0; valid_i = 1'b1; idx_i = 2'd1; data_i = 32'hB3;
    #1;
    checks++; if (b_ready_o !== 1'b1 || b_cnt_o[1] !== 3'd1) begin failures++; $display("FAIL limit_reenable got=%0b/%0d exp=1/1", b_ready_o, b_cnt_o[1]); end
    valid_i = 1'b0;
  endtask

  task automatic test_simul_push_pop;
    do_reset();
    push_a(32'hD0, 2'd0);
    push_a(32'hD1, 2'd0);
    valid_i = 1'b1; data_i = 32'hD2; idx_i = 2'd0; ready_i = 1'b1;
    cyc();
    checks++; if (a_usage_o !== 3'd2 || a_cnt_o[0] !== 3'd2) begin failures++; $display("FAIL simul_same got=%0d/%0d exp=2/2", a_usage_o, a_cnt_o[0]); end
    checks++; if (a_data_o !== 32'hD1) begin failures++; $display("FAIL simul_same_head got=%0h exp=d1", a_data_o); end
    data_i = 32'hD3; idx_i = 2'd3;
    cyc();
    checks++; if (a_usage_o !== 3'd2 || a_cnt_o[0] !== 3'd1 || a_cnt_o[3] !== 3'd1) begin
      failures++; $display("FAIL simul_diff got=%0d/%0d/%0d exp=2/1/1", a_usage_o, a_cnt_o[0], a_cnt_o[3]);
    end
    checks++; if (a_data_o !== 32'hD2) begin failures++; $display("FAIL simul_diff_head got=%0h exp=d2", a_data_o); end
    valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic test_full_wrap;
    logic [31:0] q[$];
    int sent, got;
    logic exp_rdy, do_push, do_pop;
    do_reset();
    sent = 0; got = 0;
    for (int n = 0; n < 300 && got < 10; n++) begin
      valid_i = (sent < 10); data_i = 32'hC0 + sent; idx_i = 2'(sent % 4);
      ready_i = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (q.size() < 3);
      checks++; if (c_ready_o !== exp_rdy) begin failures++; $display("FAIL wrap_ready n=%0d got=%0b exp=%0b", n, c_ready_o, exp_rdy); end
      if (q.size() > 0) begin
        checks++; if (c_valid_o !== 1'b1 || c_data_o !== q[0]) begin failures++; $display("FAIL wrap_head n=%0d got=%0b/%0h exp=1/%0h", n, c_valid_o, c_data_o, q[0]); end
      end
      do_pop = ready_i && (q.size() > 0);
      do_push = valid_i && exp_rdy;
      if (do_pop) begin void'(q.pop_front()); got++; end
      if (do_push) begin q.push_back(data_i); sent++; end
      cyc();
    end
    valid_i = 1'b0; ready_i = 1'b0;
    checks++; if (got != 10) begin failures++; $display("FAIL wrap_timeout got=%0d exp=10", got); end
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = 32'hCA + i; idx_i = 2'(i);
      cyc();
    end
    checks++; if (c_usage_o !== 2'd3) begin failures++; $display("FAIL full_usage got=%0d exp=3", c_usage_o); end
    ready_i = 1'b1; idx_i = 2'd3;
    #1;
    checks++; if (c_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", c_ready_o); end
    cyc();
    valid_i = 1'b0; ready_i = 1'b0;
    checks++; if (c_usage_o !== 2'd2 || c_data_o !== 32'hCB) begin failures++; $display("FAIL full_pop got=%0d/%0h exp=2/cb", c_usage_o, c_data_o); end
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (a_usage_o !== 3'd0 || a_valid_o !== 1'b0 || a_cnt_o !== 12'h0 || a_data_o !== 32'h0) begin
      failures++; $display("FAIL %s_clear got=%0d/%0b/%0h/%0h exp=0/0/0/0", tag, a_usage_o, a_valid_o, a_cnt_o, a_data_o);
    end
  endtask

  task automatic test_flush_reset;
    do_reset();
    push_a(32'hE0, 2'd0); push_a(32'hE1, 2'd1); push_a(32'hE2, 2'd2);
    flush = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hEE; idx_i = 2'd3;
    #1;
    checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", a_ready_o); end
    cyc();
    flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    check_cleared("flush");
    push_a(32'hF0, 2'd1);
    checks++; if (a_usage_o !== 3'd1 || a_data_o !== 32'hF0 || a_idx_o !== 2'd1) begin
      failures++; $display("FAIL flush_after got=%0d/%0h/%0d exp=1/f0/1", a_usage_o, a_data_o, a_idx_o);
    end
    push_a(32'hF1, 2'd0); push_a(32'hF2, 2'd2);
    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hEE; idx_i = 2'd3;
    cyc();
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    check_cleared("rst");
    push_a(32'hF3, 2'd2);
    checks++; if (a_usage_o !== 3'd1 || a_data_o !== 32'hF3 || a_idx_o !== 2'd2) begin
      failures++; $display("FAIL rst_after got=%0d/%0h/%0d exp=1/f3/2", a_usage_o, a_data_o, a_idx_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_per_source_limit();
    test_simul_push_pop();
    test_full_wrap();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_xbar_out_fifo.md
# stream_xbar_out_fifo

Per-output buffering stage that sits directly downstream of one crossbar output port and consumes its `data`/`idx`/`valid`/`ready` stream. It stores up to `Depth` beats in order and tracks how many stored beats came from each crossbar input. It stops accepting from any input that already holds `MaxPerInp` entries, so a single busy source cannot monopolise the buffer. Its `ready_o` is purely registered-state driven, which cuts the combinational ready path from the consumer back into the crossbar arbiter.

## Interface
- `NumInp`, default 0: number of crossbar inputs; must be > 0.
- `Depth`, default 4: buffer entries; must be ≥ 1; need not be a power of two.
- `MaxPerInp`, default `Depth`: maximum stored entries per source index, range 1..`Depth`; `Depth` disables the limit.
- `payload_t`, default `logic [31:0]`: beat payload type.
- `IdxWidth` (derived, do not override): `NumInp > 1 ? $clog2(NumInp) : 1`.
- `CntWidth` (derived, do not override): `$clog2(Depth+1)`.
- `clk_i`, input, 1: clock, rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `flush_i`, input, 1: synchronous clear of all contents.
- `data_i`, input, `payload_t`: beat from the crossbar output.
- `idx_i`, input, `IdxWidth`: source input index of the beat.
- `valid_i`, input, 1: beat valid.
- `ready_o`, output, 1: beat accepted when high together with `valid_i`.
- `data_o`, output, `payload_t`: head beat; `'0` when `valid_o` is low.
- `idx_o`, output, `IdxWidth`: head source index; `'0` when `valid_o` is low.
- `valid_o`, output, 1: buffer is non-empty.
- `ready_i`, input, 1: consumer accepts the head beat.
- `usage_o`, output, `CntWidth`: number of stored entries.
- `cnt_o`, output, `[NumInp-1:0][CntWidth]`: stored entries per source index.

## Operation
- Push: `valid_i && ready_o`. The beat and index are written at `wr_ptr`, and `wr_ptr` advances.
- Pop: `valid_o && ready_i`. `rd_ptr` advances.
- Pointers wrap from `Depth-1` to 0.
- `ready_o = !flush_i && (usage < Depth) && (cnt[idx_i] < MaxPerInp)`.
  - `ready_o` depends only on state, `idx_i` and `flush_i`.
  - It never depends on `ready_i`; a pop in the same cycle does not free a slot for a push.
- `ready_o` may depend on `idx_i`. The crossbar holds `idx_i` stable while `valid_i` is high, so this is protocol-safe.
- `usage`: +1 on push only, −1 on pop only, unchanged when both happen in the same cycle.
- `cnt[k]`: +1 on a push with `idx_i==k`, −1 on a pop with head idx `k`. It is unchanged if both happen for the same `k`, and updates independently if the indices differ.
- Ordering is strictly FIFO across all sources; there is no per-source reordering.
- `flush_i` (lower priority than `rst_i`) clears the pointers, `usage` and all `cnt` at the next edge. Any handshake offered in that cycle is discarded: `ready_o` is low, and a pop that cycle is not counted.
- Output stability: when `valid_o && !ready_i`, `data_o` and `idx_o` hold next cycle. This is AXI-compliant.
- Storage RAM is not reset. Outputs are masked to `'0` when the buffer is empty.

## Timing
- Reset values: `valid_o=0`, `ready_o=1` (when `flush_i=0` and `MaxPerInp≥1`), `usage_o=0`, `cnt_o='0`, `data_o='0`, `idx_o='0`.
- Latency: a beat pushed at edge N is visible at `data_o` with `valid_o=1` after edge N. This is one cycle, with no fall-through.
- Throughput: 1 beat/cycle sustained when `Depth ≥ 2` and the limits allow it. With `Depth=1`, throughput is 1 beat every 2 cycles.
- Full (`usage==Depth`): `ready_o=0` even if `ready_i=1` in that cycle.
- Empty: a pop is impossible; `ready_i` is ignored.
- Asserting `rst_i` mid-transfer drops all contents at the next edge, with the same values as reset.
- Assertions:
  - `idx_i < NumInp` when `valid_i` is high.
  - `1 ≤ MaxPerInp ≤ Depth`.
  - `usage == Σcnt`.
  - `cnt[k] ≤ MaxPerInp`.

## Structure
- No new package. The derived widths are local parameters; reuse `cf_math_pkg::idx_width` for `IdxWidth`.
- Single module, with no sub-module:
  - The existing fifo primitives use an asynchronous active-low reset, so the pointers, storage and counter array are implemented inline.
  - The per-source counters are a generate loop of `CntWidth` registers with a unified inc/dec rule.

## Test plan
- **Reset and fill:** `rst_i` high 2 cycles. Then, with `ready_i=0`, `Depth=4`, `MaxPerInp=4`, push `0xA0..0xA3` from idx 0,1,2,3.
  - Required: `usage_o` goes 1,2,3,4, then `ready_o=0`, and every `cnt_o[k]=1`.
- **FIFO drain:** continue from the fill, set `ready_i=1`.
  - Required: `data_o`/`idx_o` sequence is `A0/0, A1/1, A2/2, A3/3`, then `valid_o=0` and `data_o=0`.
- **Per-source limit:** `MaxPerInp=2`, idx 1 pushes 3 beats with `ready_i=0`.
  - Required: the first two are accepted and `ready_o=0` on the third.
  - Switching `idx_i` to 2 gives `ready_o=1`.
  - One pop of an idx-1 head re-enables idx 1 on the next cycle.
- **Simultaneous push/pop:** `usage=2` with head idx 0. Push idx 0 and pop in the same cycle.
  - Required: `usage_o=2` and `cnt_o[0]` unchanged.
  - Same push/pop with push idx 3: `cnt_o[0]` −1 and `cnt_o[3]` +1.
- **Full boundary and wrap:** `Depth=3`, 10 pushes/pops with random `ready_i`.
  - Required: order preserved across pointer wrap.
  - With full and `ready_i=1`, `ready_o` stays 0 that cycle.
- **Flush/reset mid-operation:** with 3 entries, assert `flush_i` together with `valid_i=1` and `ready_i=1`.
  - Required: next cycle `usage_o=0`, `valid_o=0`, all `cnt_o=0`, and the offered beat is not stored.
  - Repeat with `rst_i`: identical result.
